// File: rtl/obf_lock_pkg.sv
// Shared types for the obfuscated lock FSM: operating modes, functional states, decoy LFSR taps.
// The decoy LFSR is only instantiated when OBF_DECOY_EN is defined.
package obf_lock_pkg;

    typedef enum logic [1:0] {
        LOCK  = 2'd0,
        FUNC  = 2'd1,
        BHOLE = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        S0_N = 3'd0,
        S1_N = 3'd1,
        S2_N = 3'd2,
        S3_N = 3'd3,
        S4_N = 3'd4
    } func_state_e;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic lfsrFeedback(input logic [7:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/obf_func_core.sv
// Five-state functional FSM that runs once the lock is open; out pulses on the S4_N,b=1 transition.
module obf_func_core
    import obf_lock_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic b_i,
    input  logic clr_i,
    output logic out_o
);

    func_state_e state_q;
    logic        out_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            state_q <= S0_N;
            out_q   <= 1'b0;
        end else if (en_i) begin
            out_q <= 1'b0;
            case (state_q)
                S0_N: state_q <= b_i ? S2_N : S1_N;
                S1_N: state_q <= b_i ? S2_N : S3_N;
                S2_N: state_q <= b_i ? S4_N : S3_N;
                S3_N: state_q <= S4_N;
                S4_N: begin
                    state_q <= b_i ? S0_N : S1_N;
                    out_q   <= b_i;
                end
                default: state_q <= S0_N;
            endcase
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/obf_lock_fsm.sv
// Key-sequence lock with retry budget and blackhole in front of the functional FSM.
// Define OBF_DECOY_EN to drive out from a decoy LFSR while locked or blackholed.
module obf_lock_fsm
    import obf_lock_pkg::*;
#(
    parameter int                        SYM_W     = 1,
    parameter int                        KEY_LEN   = 5,
    parameter logic [KEY_LEN*SYM_W-1:0]  KEY       = 5'b10001,
    parameter int                        MAX_TRIES = 1,
    parameter logic [7:0]                LFSR_SEED = 8'hA5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           x_valid,
    input  logic [SYM_W-1:0]               x,
    input  logic                           relock,
    output logic                           out,
    output logic                           unlocked,
    output logic                           blackholed,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

    localparam int IDX_W  = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int FCNT_W = $clog2(MAX_TRIES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(KEY_LEN - 1);
    localparam logic [FCNT_W-1:0] LAST_TRY  = FCNT_W'(MAX_TRIES - 1);
    localparam logic [FCNT_W-1:0] TRIES_MAX = FCNT_W'(MAX_TRIES);

    mode_e             mode_q;
    logic [IDX_W-1:0]  idx_q;
    logic [FCNT_W-1:0] fail_q;
    logic              unlocked_q;
    logic              blackholed_q;
    logic [SYM_W-1:0]  keySym;
    logic              coreOut;

    // Symbol 0 sits in the most-significant slice of KEY
    assign keySym = KEY[(KEY_LEN - 1 - int'(idx_q)) * SYM_W +: SYM_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q       <= LOCK;
            idx_q        <= '0;
            fail_q       <= '0;
            unlocked_q   <= 1'b0;
            blackholed_q <= 1'b0;
        end else begin
            case (mode_q)
                LOCK: begin
                    if (relock) begin
                        idx_q <= '0;
                    end else if (x_valid) begin
                        if (x == keySym) begin
                            if (idx_q == LAST_IDX) begin
                                mode_q     <= FUNC;
                                idx_q      <= '0;
                                unlocked_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end else if (fail_q == LAST_TRY) begin
                            mode_q       <= BHOLE;
                            idx_q        <= '0;
                            fail_q       <= TRIES_MAX;
                            blackholed_q <= 1'b1;
                        end else begin
                            idx_q  <= '0;
                            fail_q <= fail_q + FCNT_W'(1);
                        end
                    end
                end
                FUNC: begin
                    if (relock) begin
                        mode_q     <= LOCK;
                        idx_q      <= '0;
                        fail_q     <= '0;
                        unlocked_q <= 1'b0;
                    end
                end
                BHOLE: begin
                end
                default: begin
                    mode_q       <= LOCK;
                    idx_q        <= '0;
                    unlocked_q   <= 1'b0;
                    blackholed_q <= 1'b0;
                end
            endcase
        end
    end

    // Core is held cleared outside FUNC so every unlock starts from S0_N
    obf_func_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (x_valid && (mode_q == FUNC) && !relock),
        .b_i   (x[0]),
        .clr_i ((mode_q != FUNC) || relock),
        .out_o (coreOut)
    );

`ifdef OBF_DECOY_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsrFeedback(lfsr_q)};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (x_valid && (mode_q != FUNC)) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = (mode_q == FUNC) ? coreOut : lfsr_q[0];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign out         = coreOut;
`endif

    assign unlocked   = unlocked_q;
    assign blackholed = blackholed_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_obf_lock_fsm.sv
// Scoreboard bench for obf_lock_fsm with key 10001 and a three-attempt retry budget.
module tb_obf_lock_fsm;

    typedef struct {
        logic       eOut;
        logic       eUnl;
        logic       eBh;
        logic [1:0] eFail;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       x_valid = 1'b0;
    logic [0:0] x = 1'b0;
    logic       relock = 1'b0;
    logic       out;
    logic       unlocked;
    logic       blackholed;
    logic [1:0] fail_cnt;

    exp_t expQ[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    obf_lock_fsm #(
        .SYM_W     (1),
        .KEY_LEN   (5),
        .KEY       (5'b10001),
        .MAX_TRIES (3),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_valid    (x_valid),
        .x          (x),
        .relock     (relock),
        .out        (out),
        .unlocked   (unlocked),
        .blackholed (blackholed),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    // One expectation is queued per edge; the monitor retires one per falling edge
    task automatic applyStimulus(input logic rn, input logic v, input logic xv, input logic rl,
                                 input logic o, input logic u, input logic bh, input logic [1:0] f,
                                 input string name);
        exp_t e;
        rst_n   = rn;
        x_valid = v;
        x       = xv;
        relock  = rl;
        e.eOut  = o;
        e.eUnl  = u;
        e.eBh   = bh;
        e.eFail = f;
        e.name  = name;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (out !== e.eOut || unlocked !== e.eUnl || blackholed !== e.eBh || fail_cnt !== e.eFail) begin
            errors++;
            $display("[TB] FAIL %s: got out=%b unl=%b bh=%b fail=%0d, want out=%b unl=%b bh=%b fail=%0d",
                     e.name, out, unlocked, blackholed, fail_cnt, e.eOut, e.eUnl, e.eBh, e.eFail);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            checkOutput(cur);
        end
    end

    initial begin
        // Reset, including reset winning over a valid symbol
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "reset");
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, "reset_over_valid");

        // Two failed attempts: 1,1 then 0
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, "try1_sym0");
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 1, "try1_miss");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 2, "try2_miss");
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 2, "idle_hold");

        // Correct key with a gap in x_valid
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 2, "key_s0");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 2, "key_s1");
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 2, "key_gap");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 2, "key_s2");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 2, "key_s3");
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 2, "unlock_after_fails");

        // Functional path S0->S2->(hold)->S4->S0 with the out pulse and its hold
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 2, "f_s0_to_s2");
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 2, "f_idle");
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 2, "f_s2_to_s4");
        applyStimulus(1, 1, 1, 0, 1, 1, 0, 2, "f_s4_out");
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 2, "f_out_hold");
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 2, "f_s0_to_s1");
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 2, "f_s1_to_s3");
        applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, "relock_in_s3");

        // relock in LOCK restarts the sequence without a failure
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, "rk_s0");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, "rk_s1");
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, "relock_in_lock");
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, "rk2_s0");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, "rk2_s1");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, "rk2_s2");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, "rk2_s3");
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 0, "reunlock");

        // Fresh S0 after re-unlock; S2->S3 and S3 ignores b; S4,b=0 gives no pulse
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 0, "g_s0_to_s2");
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 0, "g_s2_to_s3");
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 0, "g_s3_to_s4");
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 0, "g_s4_b0_to_s1");
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 0, "g_s1_to_s2");
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 0, "g_s2_to_s4");
        applyStimulus(1, 1, 1, 0, 1, 1, 0, 0, "g_s4_out");
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, "relock_idle");

        // Exhaust the retry budget: 0, 0, then 1,1
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, "bh_miss1");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 2, "bh_miss2");
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 2, "bh_s0");
        applyStimulus(1, 1, 1, 0, 0, 0, 1, 3, "blackhole");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, i[0], (i % 5) == 4, 0, 0, 1, 3, $sformatf("bh_absorb%0d", i));
        end

        // Reset leaves the blackhole and the key works again
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, "bh_reset");
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, "post_s0");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, "post_s1");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, "post_s2");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, "post_s3");
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 0, "post_unlock");
        x_valid = 1'b0;
        relock  = 1'b0;

        for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
            @(negedge clk);
            #1;
        end
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obf_lock_fsm.md
Name: obf_lock_fsm

Overview:
Parametrised successor to the group's 5-bit obfuscated FSM. A lock front-end consumes a KEY_LEN-symbol unlock sequence of SYM_W-bit symbols under a valid qualifier, with a configurable retry budget before entering a blackhole. Once unlocked, the same 5-state functional FSM (S0_N..S4_N) runs on x[0]. Adds a relock request and status outputs; sits between the stimulus/IO wrapper and the lab's output checker.

Parameters:
SYM_W, 1, bits per key symbol and width of x
KEY_LEN, 5, number of symbols in the unlock sequence (>=1)
KEY, 5'b10001, KEY_LEN*SYM_W-bit key; symbol 0 = most-significant SYM_W slice
MAX_TRIES, 1, number of sequence attempts before blackhole (>=1; 1 = first mismatch is fatal)
LFSR_SEED, 8'hA5, nonzero seed for the decoy LFSR (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous, active-low reset
x_valid  in  1  qualifies x; state advances only when high
x  in  SYM_W  key symbol in lock mode; x[0] is the data bit in functional mode
relock  in  1  pulse: return to lock mode from functional mode
out  out  1  registered functional output
unlocked  out  1  high while in functional mode
blackholed  out  1  high while in blackhole
fail_cnt  out  $clog2(MAX_TRIES+1)  failed attempts so far

Behaviour:
- Reset (rst_n=0 at posedge): mode=LOCK, key index=0, fail_cnt=0, func state=S0_N, out=0, unlocked=0, blackholed=0. Reset overrides everything, including blackhole.
- Priority per edge: reset > relock > x_valid. With x_valid=0 and no relock, all registers hold, out included.
- LOCK mode, x_valid=1: compare x to key symbol[idx]. On match with idx<KEY_LEN-1: idx++. On match with idx=KEY_LEN-1: mode=FUNC, func state=S0_N, idx=0, unlocked=1 next cycle. On mismatch: if fail_cnt+1==MAX_TRIES, mode=BHOLE and fail_cnt=MAX_TRIES; else fail_cnt++ and idx=0. The mismatching symbol is never re-evaluated as symbol 0. out=0 throughout LOCK mode.
- BHOLE mode: absorbing; ignores x_valid and relock; out=0, blackholed=1. Exit only via reset.
- FUNC mode, x_valid=1, b=x[0]: S0_N: b?S2_N:S1_N. S1_N: b?S2_N:S3_N. S2_N: b?S4_N:S3_N. S3_N: ->S4_N. S4_N: b?S0_N:S1_N. out<=1 only on the S4_N,b=1 transition; otherwise out<=0. Latency: out is visible in the cycle after the qualifying edge.
- relock=1 in FUNC mode: next edge gives mode=LOCK, idx=0, fail_cnt=0, out=0, func state=S0_N; any x_valid in the same cycle is ignored. relock in LOCK mode restarts idx=0 without counting a failure. relock in BHOLE mode has no effect.
- Minimum case KEY_LEN=1: a single matching symbol unlocks.
- Unlock timing: unlock completes on the KEY_LEN-th valid edge; gaps in x_valid are allowed between symbols.

Optional Feature:
Macro OBF_DECOY_EN. When defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed LFSR_SEED on reset) advances on every x_valid edge while in LOCK or BHOLE, and out is driven with LFSR bit 0 instead of 0. This masks lock state from observers. FUNC behaviour is unchanged and the LFSR holds in FUNC mode. When undefined, no LFSR is built and out=0 outside FUNC.

Decomposition:
- Package obf_lock_pkg: mode enum (LOCK, FUNC, BHOLE), func-state enum S0_N..S4_N (3-bit), LFSR tap constant.
- Sub-module obf_func_core: the 5-state functional FSM with out register, inputs en/b/clr.
- The key/retry/mode logic stays in the top level.

Test Plan:
- Defaults: reset, then valid stream 1,0,0,0,1 -> unlocked=1 after the 5th edge. Next, 1,1 -> state S2_N then S4_N. Next, 1 -> out=1 for one cycle.
- Defaults: input 1,1 -> blackholed=1 after the 2nd edge and fail_cnt=1. 20 further symbols plus relock -> stays blackholed with out=0. rst_n=0 -> back to LOCK.
- MAX_TRIES=3: two bad attempts (1,1 and 0), then 1,0,0,0,1 -> unlocked with fail_cnt=2. A third bad attempt instead -> blackholed with fail_cnt=3.
- SYM_W=4, KEY_LEN=3, KEY=12'hA5C: valid A,5,C with x_valid gaps of 2 idle cycles -> unlocked on the 3rd valid edge. A,5,D -> blackholed.
- relock in FUNC mid-sequence (state S3_N) together with x_valid=1 -> next cycle LOCK, fail_cnt=0, out=0. Re-entering the key re-unlocks.
- OBF_DECOY_EN, seed A5: in LOCK, out follows the precomputed LFSR bit-0 sequence per valid edge. After unlock, out matches the non-decoy build exactly.
